// File: rtl/dsss_pkg.sv
// rtl/dsss_pkg.sv - shared DSSS constants, FSM state type and magnitude helper
package dsss_pkg;
  localparam int         CHIP_LEN = 31;
  localparam int         SAMPLE_W = 3;
  localparam int         ACC_W    = 8;
  localparam logic [4:0] PN_TAPS  = 5'b00101;
  localparam logic [4:0] PN_SEED  = 5'b00001;

  typedef enum logic [1:0] {ACQ, SLIP, TRACK} state_t;

  function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction
endpackage

// File: rtl/despread_rx_if.sv
// rtl/despread_rx_if.sv - sample input and bit/debug output bundle of the despreader
interface despread_rx_if;
  import dsss_pkg::*;
  logic                sample_ena;
  logic [SAMPLE_W-1:0] noised_data;
  logic                out_data;
  logic                out_valid;
  logic                locked;
  logic [ACC_W-1:0]    corr;

  modport master (output sample_ena, noised_data,
                  input  out_data, out_valid, locked, corr);
  modport slave  (input  sample_ena, noised_data,
                  output out_data, out_valid, locked, corr);
endinterface

// File: rtl/pn_gen.sv
// rtl/pn_gen.sv - 5-bit Fibonacci LFSR (x^5+x^2+1) producing one chip per advance
module pn_gen
  import dsss_pkg::*;
#(
  parameter logic [4:0] SEED = PN_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic load,
  output logic chip
);
  logic [4:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & PN_TAPS);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_lfsr <= SEED;
    end else if (advance) begin
      r_lfsr <= {w_fb, r_lfsr[4:1]};
    end
  end

  assign chip = r_lfsr[0];
endmodule

// File: rtl/despread_rx.sv
// rtl/despread_rx.sv - sliding-correlator DSSS receiver: acquire code phase, then one bit per 31 chips
module despread_rx #(
  parameter int unsigned THRESH   = 20,
  parameter int unsigned LOSS_CNT = 3,
  parameter logic [4:0]  PN_SEED  = dsss_pkg::PN_SEED
) (
  input  logic          clk31,
  input  logic          rst,
  despread_rx_if.slave  bus
);
  import dsss_pkg::*;

  localparam logic [ACC_W-1:0] TH8     = ACC_W'(THRESH);
  localparam logic [2:0]       LC3     = 3'(LOSS_CNT);
  localparam logic [4:0]       LAST_CH = 5'(CHIP_LEN - 1);

  state_t                  r_state;
  logic        [4:0]       r_cnt;
  logic        [2:0]       r_loss;
  logic signed [ACC_W-1:0] r_acc;
  logic        [ACC_W-1:0] r_corr;
  logic                    r_out_data;
  logic                    r_out_valid;
  logic                    r_locked;

  logic                    w_chip;
  logic                    w_run;
  logic                    w_wend;
  logic                    w_pass;
  logic signed [ACC_W-1:0] w_smp;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_sum;

  // A SLIP sample is swallowed without touching the code, delaying it one chip.
  assign w_run  = bus.sample_ena && (r_state != SLIP);
  assign w_wend = w_run && (r_cnt == LAST_CH);

  // Sign-extend before negating so that -(-4) becomes +4.
  assign w_smp  = {{(ACC_W-SAMPLE_W){bus.noised_data[SAMPLE_W-1]}}, bus.noised_data};
  assign w_prod = w_chip ? w_smp : -w_smp;
  assign w_sum  = r_acc + w_prod;
  assign w_pass = mag(w_sum) >= TH8;

  pn_gen #(.SEED(PN_SEED)) u_pn (
    .clk     (clk31),
    .rst     (rst),
    .advance (w_run && !w_wend),
    .load    (w_wend),
    .chip    (w_chip)
  );

  always_ff @(posedge clk31) begin
    if (rst) begin
      r_state     <= ACQ;
      r_cnt       <= '0;
      r_loss      <= '0;
      r_acc       <= '0;
      r_corr      <= '0;
      r_out_data  <= 1'b0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.sample_ena) begin
        if (r_state == SLIP) begin
          r_state <= ACQ;
        end else if (w_wend) begin
          r_acc  <= '0;
          r_cnt  <= '0;
          r_corr <= w_sum;
          if (r_state == ACQ) begin
            if (w_pass) begin
              r_state     <= TRACK;
              r_locked    <= 1'b1;
              r_out_valid <= 1'b1;
              r_out_data  <= ~w_sum[ACC_W-1];
              r_loss      <= '0;
            end else begin
              r_state <= SLIP;
            end
          end else begin
            r_out_valid <= 1'b1;
            r_out_data  <= ~w_sum[ACC_W-1];
            if (w_pass) begin
              r_loss <= '0;
            end else if (r_loss + 3'd1 >= LC3) begin
              r_state  <= ACQ;
              r_locked <= 1'b0;
              r_loss   <= '0;
            end else begin
              r_loss <= r_loss + 3'd1;
            end
          end
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.locked    = r_locked;
  assign bus.corr      = r_corr;
endmodule

// File: tb/tb_despread_rx.sv
// tb/tb_despread_rx.sv - directed self-checking bench for despread_rx
module tb_despread_rx;
  localparam logic [0:30] PN = 31'b1000010010110011111000110111010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  despread_rx_if bus();
  despread_rx dut (.clk31(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_pass   = 0;

  int acc_cnt;
  int lock_rise;
  bit lock_drop;
  logic prev_lock = 1'b0;
  int q_cnt[$];
  logic q_data[$];
  logic signed [7:0] q_corr[$];
  logic q_lock[$];
  int win_sum[$];
  int wsum;
  bit tx_bits[0:255];

  always @(posedge clk) if (!rst && bus.sample_ena === 1'b1) acc_cnt++;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q_cnt.push_back(acc_cnt);
      q_data.push_back(bus.out_data);
      q_corr.push_back(bus.corr);
      q_lock.push_back(bus.locked);
    end
    if (prev_lock === 1'b1 && bus.locked === 1'b0) lock_drop = 1'b1;
    if (prev_lock !== 1'b1 && bus.locked === 1'b1 && lock_rise < 0) lock_rise = acc_cnt;
    prev_lock = bus.locked;
  end

  task automatic clear_log();
    q_cnt.delete(); q_data.delete(); q_corr.delete(); q_lock.delete(); win_sum.delete();
    acc_cnt = 0; wsum = 0; lock_rise = -1; lock_drop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sample_ena  = 1'b0;
      bus.noised_data = 3'($urandom);
    end
  endtask

  task automatic apply_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    bus.sample_ena = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_raw(input int v_in, input int ph, input int gap);
    int v;
    v = v_in;
    if (v > 3) v = 3;
    if (v < -4) v = -4;
    while (int'($urandom_range(0, 99)) < gap) begin
      @(negedge clk);
      bus.sample_ena  = 1'b0;
      bus.noised_data = 3'($urandom);
    end
    @(negedge clk);
    bus.sample_ena  = 1'b1;
    bus.noised_data = 3'(v);
    wsum += v * (PN[ph] ? 1 : -1);
    if (ph == 30) begin
      win_sum.push_back(wsum);
      wsum = 0;
    end
  endtask

  task automatic send_range(input int j0, input int n, input int noise, input int gap);
    for (int k = 0; k < n; k++) begin
      int j, ph, v;
      j  = j0 + k;
      ph = j % 31;
      v  = ((PN[ph] ~^ tx_bits[j / 31]) != 1'b0) ? 1 : -1;
      if (noise != 0) v += int'($urandom_range(0, 2)) - 1;
      send_raw(v, ph, gap);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.sample_ena  = 1'($urandom);
      bus.noised_data = 3'($urandom);
      @(negedge clk);
      n_checks += 4;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid cyc %0d got %b want 0", i, bus.out_valid); else n_pass++;
      if (bus.out_data !== 1'b0) $display("FAIL reset_out_data cyc %0d got %b want 0", i, bus.out_data); else n_pass++;
      if (bus.locked !== 1'b0) $display("FAIL reset_locked cyc %0d got %b want 0", i, bus.locked); else n_pass++;
      if (bus.corr !== 8'd0) $display("FAIL reset_corr cyc %0d got %0d want 0", i, bus.corr); else n_pass++;
    end
    rst = 1'b0;
    bus.sample_ena = 1'b0;
    clear_log();
  endtask

  task automatic test_aligned();
    int exp_c[3] = '{31, -31, 31};
    bit exp_d[3] = '{1'b1, 1'b0, 1'b1};
    tx_bits[0] = 1'b1; tx_bits[1] = 1'b0; tx_bits[2] = 1'b1;
    send_range(0, 93, 0, 0);
    idle(2);
    n_checks++;
    if (q_cnt.size() != 3) $display("FAIL aligned_count got %0d want 3", q_cnt.size()); else n_pass++;
    for (int k = 0; k < 3 && k < q_cnt.size(); k++) begin
      n_checks += 4;
      if (q_cnt[k] != 31 * (k + 1)) $display("FAIL aligned_time bit %0d got %0d want %0d", k, q_cnt[k], 31 * (k + 1)); else n_pass++;
      if (q_data[k] !== exp_d[k]) $display("FAIL aligned_data bit %0d got %b want %b", k, q_data[k], exp_d[k]); else n_pass++;
      if (int'(q_corr[k]) != exp_c[k]) $display("FAIL aligned_corr bit %0d got %0d want %0d", k, q_corr[k], exp_c[k]); else n_pass++;
      if (q_lock[k] !== 1'b1) $display("FAIL aligned_locked bit %0d got %b want 1", k, q_lock[k]); else n_pass++;
    end
    n_checks++;
    if (lock_rise != 31) $display("FAIL aligned_lock_rise got %0d want 31", lock_rise); else n_pass++;
  endtask

  task automatic test_offset();
    apply_reset(2);
    for (int i = 0; i < 32; i++) tx_bits[i] = 1'b1;
    send_range(24, 255, 0, 0);
    idle(2);
    n_checks += 2;
    if (q_cnt.size() != 1) $display("FAIL offset_count got %0d want 1", q_cnt.size()); else n_pass++;
    if (lock_rise != 255) $display("FAIL offset_lock_rise got %0d want 255", lock_rise); else n_pass++;
    if (q_cnt.size() >= 1) begin
      n_checks += 3;
      if (q_cnt[0] != 255) $display("FAIL offset_time got %0d want 255", q_cnt[0]); else n_pass++;
      if (int'(q_corr[0]) != 31) $display("FAIL offset_corr got %0d want 31", q_corr[0]); else n_pass++;
      if (q_data[0] !== 1'b1) $display("FAIL offset_data got %b want 1", q_data[0]); else n_pass++;
    end
  endtask

  task automatic test_noise();
    int errs, cerrs;
    apply_reset(2);
    for (int i = 0; i < 201; i++) tx_bits[i] = 1'($urandom);
    send_range(0, 31, 0, 0);
    send_range(31, 200 * 31, 1, 0);
    idle(2);
    errs = 0; cerrs = 0;
    for (int k = 0; k < q_data.size() && k < 201; k++) begin
      if (q_data[k] !== tx_bits[k]) errs++;
      if (k < win_sum.size() && int'(q_corr[k]) != win_sum[k]) cerrs++;
    end
    n_checks += 4;
    if (q_data.size() != 201) $display("FAIL noise_count got %0d want 201", q_data.size()); else n_pass++;
    if (errs != 0) $display("FAIL noise_bit_errors got %0d want 0", errs); else n_pass++;
    if (cerrs != 0) $display("FAIL noise_corr_errors got %0d want 0", cerrs); else n_pass++;
    if (lock_drop) $display("FAIL noise_lock_drop got 1 want 0"); else n_pass++;
  endtask

  task automatic test_loss();
    clear_log();
    for (int k = 0; k < 93; k++) send_raw(0, k % 31, 0);
    idle(2);
    n_checks++;
    if (q_cnt.size() != 3) $display("FAIL loss_count got %0d want 3", q_cnt.size()); else n_pass++;
    for (int k = 0; k < 3 && k < q_cnt.size(); k++) begin
      n_checks += 3;
      if (int'(q_corr[k]) != 0) $display("FAIL loss_corr win %0d got %0d want 0", k, q_corr[k]); else n_pass++;
      if (q_data[k] !== 1'b1) $display("FAIL loss_data win %0d got %b want 1", k, q_data[k]); else n_pass++;
      if (q_lock[k] !== (k < 2)) $display("FAIL loss_locked win %0d got %b want %b", k, q_lock[k], (k < 2)); else n_pass++;
    end
    tx_bits[0] = 1'b1;
    send_range(0, 31, 0, 0);
    idle(2);
    n_checks++;
    if (q_cnt.size() != 4 || q_cnt[3] != 124 || q_lock[3] !== 1'b1)
      $display("FAIL loss_relock strobes %0d want 4 (last at 124, locked)", q_cnt.size());
    else n_pass++;
  endtask

  task automatic test_gaps();
    int errs, terrs;
    apply_reset(2);
    for (int i = 0; i < 10; i++) tx_bits[i] = 1'($urandom);
    send_range(0, 310, 0, 30);
    idle(2);
    errs = 0; terrs = 0;
    for (int k = 0; k < q_cnt.size() && k < 10; k++) begin
      if (q_data[k] !== tx_bits[k]) errs++;
      if (q_cnt[k] != 31 * (k + 1) || int'(q_corr[k]) != win_sum[k]) terrs++;
    end
    n_checks += 3;
    if (q_cnt.size() != 10) $display("FAIL gaps_count got %0d want 10", q_cnt.size()); else n_pass++;
    if (errs != 0) $display("FAIL gaps_bit_errors got %0d want 0", errs); else n_pass++;
    if (terrs != 0) $display("FAIL gaps_time_corr_errors got %0d want 0", terrs); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 32; i++) tx_bits[i] = 1'b1;
    clear_log();
    send_range(0, 15, 0, 0);
    apply_reset(2);
    send_range(15, 543, 0, 0);
    idle(2);
    n_checks++;
    if (q_cnt.size() != 1) $display("FAIL rstmid_count got %0d want 1", q_cnt.size()); else n_pass++;
    if (q_cnt.size() >= 1) begin
      n_checks += 2;
      if (q_cnt[0] != 543) $display("FAIL rstmid_time got %0d want 543", q_cnt[0]); else n_pass++;
      if (int'(q_corr[0]) != 31) $display("FAIL rstmid_corr got %0d want 31", q_corr[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_wend();
    clear_log();
    send_range(558, 30, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.sample_ena  = 1'b1;
    bus.noised_data = PN[30] ? 3'd1 : 3'b111;
    @(negedge clk);
    rst = 1'b0;
    bus.sample_ena = 1'b0;
    idle(2);
    n_checks += 3;
    if (q_cnt.size() != 0) $display("FAIL rstwend_strobe got %0d want 0", q_cnt.size()); else n_pass++;
    if (bus.locked !== 1'b0) $display("FAIL rstwend_locked got %b want 0", bus.locked); else n_pass++;
    if (bus.corr !== 8'd0) $display("FAIL rstwend_corr got %0d want 0", bus.corr); else n_pass++;
  endtask

  initial begin
    bus.sample_ena  = 1'b0;
    bus.noised_data = 3'd0;
    clear_log();
    test_reset();
    test_aligned();
    test_offset();
    test_noise();
    test_loss();
    test_gaps();
    test_reset_mid();
    test_reset_wend();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/despread_rx.md
# despread_rx

Chip-rate despreading receiver for the DSSS link: the receive-side counterpart of the transmit chain (coder + add_noise). It takes one 3-bit signed noisy chip sample per accepted `clk31` cycle and correlates 31-sample windows against a local copy of the 31-chip m-sequence. It acquires code phase by sliding the local sequence one chip at a time, then recovers one data bit per 31-chip window. It sits directly after the noise channel and feeds the bit sink / error counter.

## Interface
- `THRESH`, 20: lock threshold on |correlation| (unsigned, ≤ 124).
- `LOSS_CNT`, 3: consecutive sub-threshold TRACK windows that drop lock (1..7).
- `PN_SEED`, 5'b00001: LFSR value at chip 0 of every bit period; matches the coder.
- `clk31` in 1: chip clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_ena` in 1: `noised_data` is valid this cycle.
- `noised_data` in 3: chip sample, two's complement, range -4..+3.
- `out_data` out 1: recovered bit.
- `out_valid` out 1: one-cycle strobe; `out_data` is valid.
- `locked` out 1: FSM is in TRACK.
- `corr` out 8: signed correlation of the last completed window (debug).

## Operation
- Local PN: 5-bit Fibonacci LFSR, x^5+x^2+1, period 31. Chip bit = lfsr[0]; bit 1 maps to +1, bit 0 maps to -1. Data bit 1 = sequence as generated; data bit 0 = inverted.
- Per accepted sample:
  - product = +sample if chip=1, else -sample. Sign-extend to 8 bits before negating, so -(-4)=+4.
  - acc += product. The 8-bit signed accumulator never overflows (max |31×4| = 124).
- Chip counter runs 0..30. The LFSR advances with the counter. At count 30 it reloads `PN_SEED` so the window boundary stays locked to the code period.
- FSM states: ACQ, SLIP, TRACK.
  - ACQ: integrate one window. At window end:
    - If |acc| ≥ THRESH: go to TRACK, emit the bit, set `locked`.
    - Else: go to SLIP.
  - SLIP: consume exactly one accepted sample without advancing the LFSR or chip counter. The sample is discarded. This delays the local code by one chip. Return to ACQ. Phase search wraps indefinitely; there is no retry limit.
  - TRACK: at every window end, emit the bit (`out_data` = 1 if acc ≥ 0, else 0; acc = 0 gives 1).
    - If |acc| < THRESH: increment the loss counter.
    - Else: clear the loss counter.
    - When the loss counter reaches LOSS_CNT: go to ACQ, clear `locked`, clear the loss counter. The bit from that final window is still emitted.
- At every window end: `corr` is loaded with the final acc, and acc restarts from 0, i.e. the next sample is not added to the old value.
- `sample_ena`=0: all state holds (acc, counter, LFSR, FSM). `out_valid` is not asserted.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `locked`=0, `corr`=0, acc=0, chip counter=0, LFSR=`PN_SEED`, FSM=ACQ, loss counter=0.
- Latency: `out_valid`, `out_data`, `corr` and `locked` update on the clock edge following the cycle in which the 31st sample of the window is accepted. All outputs are registered.
- `out_valid` is high for exactly 1 cycle per emitted bit. The minimum spacing is 31 cycles when `sample_ena` is held high.
- `rst` mid-window: the partial window is discarded. A bit is never emitted from a partial window.
- `rst` in the same cycle as a window end: reset wins and `out_valid` stays 0.
- Lock from an arbitrary offset d (0..30 chips): first `out_valid` after 32·d + 31 accepted samples, plus 1 cycle.

## Structure
- Shared package `dsss_pkg`:
  - chip length 31
  - PN taps and `PN_SEED`
  - sample width 3, accumulator width 8
  - FSM state enum {ACQ, SLIP, TRACK}
- The coder uses the same package constants.
- Sub-module `pn_gen`: LFSR with `advance` and `load` inputs and a `chip` output. Shared with the coder side.
- Everything else (FSM, accumulator, counters, outputs) stays in `despread_rx`.

## Test plan
- Reset: `rst`=1 for 3 cycles with random `noised_data` → all outputs 0 and `locked`=0 throughout.
- Aligned, noiseless ±1 chips, bits 1,0,1 starting at chip 0:
  - `out_valid` at accepted samples 31, 62, 93 (+1 cycle).
  - `out_data` = 1, 0, 1.
  - `corr` = +31, -31, +31.
  - `locked` rises with the first strobe.
- Offset 7 chips, constant data 1 → exactly 7 SLIPs; first `out_valid` after 255 accepted samples; `corr`=+31.
- Noise: ±1 uniform noise added, saturated to -4..+3, 200 bits after lock → zero bit errors; `locked` never drops.
- Loss: after lock, 3 windows of all-zero samples → 3 strobes with `corr`=0, `out_data`=1; `locked` falls with the third strobe; FSM returns to ACQ.
- Gaps and reset:
  - Random `sample_ena` deassertion (~30%) → bit sequence identical to the gap-free run.
  - `rst` at chip 15 of a tracked window → no strobe from that window; reacquisition proceeds from reset state.
